color_correct_matrix: RTL and testbench
=======================================

Name: color_correct_matrix

Overview:
- Pipelined 3x3 colour-correction-matrix (CCM) stage that sits directly downstream of the demosaic block.
- Consumes its oR/oG/oB/oValid pixel stream and produces white-balanced, colour-corrected 8-bit RGB for the next stage.
- Coefficients are runtime-programmable through a shadow register bank that commits only at frame boundaries.
- Tracks pixel count and flags the last pixel of each frame.

Parameters:
- width, 320, pixels per line
- height, 240, lines per frame
- COEF_W, 12, coefficient width (signed two's complement)
- FRAC, 8, fractional bits of coefficients (256 = 1.0)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- iR  in  8  unsigned red from demosaic
- iG  in  8  unsigned green
- iB  in  8  unsigned blue
- iValid  in  1  input pixel valid
- iCoefWe  in  1  coefficient write strobe
- iCoefAddr  in  4  coefficient index 0..8, row-major (0=RR,1=RG,2=RB,3=GR,...,8=BB); 9..15 ignored
- iCoefData  in  COEF_W  signed coefficient value
- oR  out  8  corrected red
- oG  out  8  corrected green
- oB  out  8  corrected blue
- oValid  out  1  output pixel valid
- oDone  out  1  one-cycle pulse with the last pixel of a frame
- oCoefPending  out  1  shadow bank holds uncommitted writes

Behaviour:
- Reset (async, active-high):
  - oR/oG/oB, oValid, oDone and all pipeline valids go to 0.
  - Pixel counter goes to 0; oCoefPending goes to 0.
  - Both the active and shadow banks load identity: diagonal 256, off-diagonal 0.
- Reset mid-frame discards all in-flight pixels; no oValid or oDone is produced for them.
- No backpressure. A pixel is accepted on every cycle where iValid=1.
- Latency is exactly 3 cycles, iValid to oValid. Throughput is 1 pixel/clk.
- Stage 1 (S1): the nine products c[i][j]*p[j] are registered.
  - p[j] is zero-extended to 9-bit signed.
  - Each product is COEF_W+9 bits, signed.
  - Products use the active bank as it stands in the accept cycle.
- Stage 2 (S2): per channel, sum the 3 products plus rounding constant 2^(FRAC-1), then register. Sum width is COEF_W+11 bits (no overflow possible).
- Stage 3 (S3): arithmetic shift right by FRAC, then clamp:
  - negative results become 0
  - results above 255 become 255
  - the clamped value is registered to oR/oG/oB.
- The valid bit travels with the data through S1–S3. When the valid bit is 0, the output data registers hold their previous value.
- Pixel counter:
  - Increments on each accepted pixel.
  - On accepting pixel index width*height-1 it wraps to 0 and tags that pixel "last".
  - oDone=1 in the same cycle the tagged pixel appears with oValid=1, and only then.
- Coefficient writes:
  - When iCoefWe=1 and iCoefAddr<=8, shadow[iCoefAddr] <= iCoefData and oCoefPending <= 1.
  - When iCoefAddr>=9, the write is ignored and oCoefPending is unchanged.
- Commit:
  - Commit happens at the end of any cycle where oCoefPending=1 and one of these holds:
    - (a) a "last" pixel is accepted this cycle, or
    - (b) the counter is 0 and iValid=0 (idle between frames or before the first frame).
  - On commit, active <= shadow and oCoefPending <= 0.
  - Pixels accepted in or before the commit cycle use the old bank. The next accepted pixel uses the new bank.
  - No commit occurs mid-frame, so a frame never mixes banks.
- Write coinciding with a commit cycle:
  - The commit copies the shadow as it was before this write.
  - The new write lands in the shadow and oCoefPending stays 1.
  - The write is committed at the next eligible cycle.
- Gaps in iValid are allowed anywhere. The counter and pipeline simply hold; oValid shows matching gaps.

Test Plan:
- Identity after reset; input (10,200,255) with iValid for 1 cycle -> exactly 3 cycles later oValid=1 and out=(10,200,255); oValid=0 the following cycle.
- Clamp: write RR=512 (2.0), RG=-256, commit while idle, input (200,50,0) -> oR=255; input (10,100,0) -> oR=0; G/B unchanged.
- Rounding: RR=128 (0.5), others 0, input R=3 -> 1.5 rounds up to oR=2; input R=1 -> 0.5 rounds up to oR=1.
- Frame/oDone with width=4, height=2: stream 8 pixels with random iValid gaps -> oDone pulses once, coincident with the 8th oValid; a second frame produces a second pulse.
- Frame-boundary commit: write RR=0 at mid-frame pixel 3 -> pixels 4..7 are still identity, oCoefPending=1; the next frame's pixel 0 gives oR=0 and oCoefPending drops after pixel 7 is accepted.
- Async reset asserted while 3 pixels are in flight -> outputs go 0 immediately with no further oValid; the counter restarts so the following 8 pixels produce oDone on the 8th.

Source files
------------

// File: rtl/color_correct_matrix.sv
`default_nettype none
// ============================================================================
// Module : color_correct_matrix
// Desc   : 3-stage pipelined 3x3 colour-correction matrix with a shadow
//          coefficient bank that commits only on frame boundaries.
// Rev    : 1.0  initial release
// ============================================================================
module color_correct_matrix #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int COEF_W = 12,
    parameter int FRAC   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        iR,
    input  logic [7:0]        iG,
    input  logic [7:0]        iB,
    input  logic              iValid,
    input  logic              iCoefWe,
    input  logic [3:0]        iCoefAddr,
    input  logic [COEF_W-1:0] iCoefData,
    output logic [7:0]        oR,
    output logic [7:0]        oG,
    output logic [7:0]        oB,
    output logic              oValid,
    output logic              oDone,
    output logic              oCoefPending
);

    localparam int NPIX   = WIDTH * HEIGHT;
    localparam int CNT_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int PROD_W = COEF_W + 9;
    localparam int SUM_W  = COEF_W + 11;

    localparam logic [CNT_W-1:0]         c_last  = CNT_W'(NPIX - 1);
    localparam logic signed [COEF_W-1:0] c_one   = COEF_W'(1 << FRAC);
    localparam logic signed [SUM_W-1:0]  c_round = SUM_W'(1 << (FRAC - 1));

    // Control state
    logic signed [COEF_W-1:0] active_q [9];
    logic signed [COEF_W-1:0] active_d [9];
    logic signed [COEF_W-1:0] shadow_q [9];
    logic signed [COEF_W-1:0] shadow_d [9];
    logic                     pend_q, pend_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     w_last_acc;
    logic                     w_commit;
    logic                     w_wr_hit;

    // Pipeline state
    logic [7:0]               w_pix    [3];
    logic signed [PROD_W-1:0] prod_q   [9];
    logic signed [PROD_W-1:0] prod_d   [9];
    logic signed [SUM_W-1:0]  sum_q    [3];
    logic signed [SUM_W-1:0]  sum_d    [3];
    logic signed [SUM_W-1:0]  w_sh     [3];
    logic [7:0]               out_q    [3];
    logic [7:0]               out_d    [3];
    logic                     v1_q, v2_q, valid_q;
    logic                     last1_q, last2_q, done_q;

    assign w_last_acc = iValid && (cnt_q == c_last);

    always_comb begin
        cnt_d = cnt_q;
        if (iValid) begin
            cnt_d = w_last_acc ? '0 : cnt_q + 1'b1;
        end

        // Idle at counter 0 is a frame gap; the last pixel closes a frame.
        w_commit = pend_q && (w_last_acc || ((cnt_q == '0) && !iValid));

        w_wr_hit = 1'b0;
        for (int i = 0; i < 9; i++) begin
            shadow_d[i] = shadow_q[i];
            active_d[i] = w_commit ? shadow_q[i] : active_q[i];
            if (iCoefWe && (iCoefAddr == 4'(i))) begin
                shadow_d[i] = iCoefData;
                w_wr_hit    = 1'b1;
            end
        end

        // A write landing in a commit cycle keeps the bank pending.
        if (w_wr_hit) begin
            pend_d = 1'b1;
        end else if (w_commit) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                active_q[i] <= ((i % 4) == 0) ? c_one : '0;
                shadow_q[i] <= ((i % 4) == 0) ? c_one : '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            for (int i = 0; i < 9; i++) begin
                active_q[i] <= active_d[i];
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign w_pix[0] = iR;
    assign w_pix[1] = iG;
    assign w_pix[2] = iB;

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            prod_d[i] = PROD_W'(active_q[i]) * PROD_W'($signed({1'b0, w_pix[i % 3]}));
        end
        for (int r = 0; r < 3; r++) begin
            sum_d[r] = SUM_W'(prod_q[3*r]) + SUM_W'(prod_q[3*r+1])
                     + SUM_W'(prod_q[3*r+2]) + c_round;
        end
        for (int r = 0; r < 3; r++) begin
            w_sh[r] = sum_q[r] >>> FRAC;
            if (w_sh[r][SUM_W-1]) begin
                out_d[r] = 8'd0;
            end else if (|w_sh[r][SUM_W-2:8]) begin
                out_d[r] = 8'd255;
            end else begin
                out_d[r] = w_sh[r][7:0];
            end
        end
    end

    // Data registers only load with a valid pixel so outputs hold across gaps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            valid_q <= 1'b0;
            last1_q <= 1'b0;
            last2_q <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 9; i++) prod_q[i] <= '0;
            for (int r = 0; r < 3; r++) begin
                sum_q[r] <= '0;
                out_q[r] <= '0;
            end
        end else begin
            v1_q    <= iValid;
            last1_q <= w_last_acc;
            v2_q    <= v1_q;
            last2_q <= v1_q && last1_q;
            valid_q <= v2_q;
            done_q  <= v2_q && last2_q;
            if (iValid) begin
                for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
            end
            if (v1_q) begin
                for (int r = 0; r < 3; r++) sum_q[r] <= sum_d[r];
            end
            if (v2_q) begin
                for (int r = 0; r < 3; r++) out_q[r] <= out_d[r];
            end
        end
    end

    assign oR           = out_q[0];
    assign oG           = out_q[1];
    assign oB           = out_q[2];
    assign oValid       = valid_q;
    assign oDone        = done_q;
    assign oCoefPending = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_color_correct_matrix.sv
`default_nettype none
// ============================================================================
// Module : tb_color_correct_matrix
// Desc   : Scoreboard bench for color_correct_matrix (4x2 frames).
// Rev    : 1.0  initial release
// ============================================================================
module tb_color_correct_matrix;

    localparam int NPIX = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  iR, iG, iB;
    logic        iValid;
    logic        iCoefWe;
    logic [3:0]  iCoefAddr;
    logic [11:0] iCoefData;
    logic [7:0]  oR, oG, oB;
    logic        oValid, oDone, oCoefPending;

    color_correct_matrix #(
        .WIDTH  (4),
        .HEIGHT (2),
        .COEF_W (12),
        .FRAC   (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .iR           (iR),
        .iG           (iG),
        .iB           (iB),
        .iValid       (iValid),
        .iCoefWe      (iCoefWe),
        .iCoefAddr    (iCoefAddr),
        .iCoefData    (iCoefData),
        .oR           (oR),
        .oG           (oG),
        .oB           (oB),
        .oValid       (oValid),
        .oDone        (oDone),
        .oCoefPending (oCoefPending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       done;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   pos      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected pixel per oValid
    exp_t e;
    always @(negedge clk) begin
        if (!reset) begin
            if (oValid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_r", 32'(oR), 32'(e.r));
                    chk("out_g", 32'(oG), 32'(e.g));
                    chk("out_b", 32'(oB), 32'(e.b));
                    chk("done", 32'(oDone), 32'(e.done));
                    chk("latency_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else if (oDone) begin
                chk("done_without_valid", 32'(oDone), 32'd0);
            end
        end
    end

    task automatic idle();
        iValid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
        exp_t x;
        iR = r; iG = g; iB = b; iValid = 1'b1;
        x.r = er; x.g = eg; x.b = eb;
        x.done = (pos == NPIX - 1);
        x.cyc  = cyc + 3;
        sb.push_back(x);
        pos = (pos + 1) % NPIX;
        @(posedge clk); #1;
        iValid = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [11:0] d);
        iCoefWe = 1'b1; iCoefAddr = a; iCoefData = d; iValid = 1'b0;
        @(posedge clk); #1;
        iCoefWe = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; iR = '0; iG = '0; iB = '0; iValid = 1'b0;
        iCoefWe = 1'b0; iCoefAddr = '0; iCoefData = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_r", 32'(oR), 32'd0);
        chk("reset_g", 32'(oG), 32'd0);
        chk("reset_b", 32'(oB), 32'd0);
        chk("reset_valid", 32'(oValid), 32'd0);
        chk("reset_done", 32'(oDone), 32'd0);
        chk("reset_pending", 32'(oCoefPending), 32'd0);
        reset = 1'b0;
        idle();

        // Identity bank after reset, single isolated pixel then rest of frame
        px(8'd10, 8'd200, 8'd255, 8'd10, 8'd200, 8'd255);
        repeat (5) idle();
        for (int i = 1; i < 8; i++)
            px(8'(i*30), 8'(255-i), 8'd7, 8'(i*30), 8'(255-i), 8'd7);
        repeat (4) idle();

        // Clamp: RR=2.0, RG=-1.0; second write lands in an idle commit cycle
        wr(4'd12, 12'd0);
        chk("ignored_addr_pending", 32'(oCoefPending), 32'd0);
        wr(4'd0, 12'd512);
        chk("pending_after_write", 32'(oCoefPending), 32'd1);
        wr(4'd1, 12'hF00);
        chk("pending_write_on_commit", 32'(oCoefPending), 32'd1);
        idle();
        chk("pending_idle_commit", 32'(oCoefPending), 32'd0);
        px(8'd200, 8'd50, 8'd0, 8'd255, 8'd50, 8'd0);
        px(8'd10, 8'd100, 8'd0, 8'd0, 8'd100, 8'd0);
        for (int i = 2; i < 8; i++)
            px(8'(i*20), 8'(i*20), 8'd5, 8'(i*20), 8'(i*20), 8'd5);
        repeat (4) idle();

        // Rounding: RR=0.5, RG=0
        wr(4'd0, 12'd128);
        wr(4'd1, 12'd0);
        idle();
        chk("pending_round_commit", 32'(oCoefPending), 32'd0);
        px(8'd3, 8'd9, 8'd1, 8'd2, 8'd9, 8'd1);
        px(8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0);
        px(8'd255, 8'd0, 8'd0, 8'd128, 8'd0, 8'd0);
        px(8'd2, 8'd77, 8'd0, 8'd1, 8'd77, 8'd0);
        for (int i = 4; i < 8; i++)
            px(8'd0, 8'(i), 8'(i), 8'd0, 8'(i), 8'(i));
        repeat (4) idle();

        // Frame-boundary commit: restore identity, then write RR=0 mid-frame
        wr(4'd0, 12'd256);
        idle();
        chk("pending_identity_commit", 32'(oCoefPending), 32'd0);
        for (int i = 0; i < 3; i++)
            px(8'(50+i), 8'(60+i), 8'(70+i), 8'(50+i), 8'(60+i), 8'(70+i));
        iCoefWe = 1'b1; iCoefAddr = 4'd0; iCoefData = 12'd0;
        px(8'd53, 8'd63, 8'd73, 8'd53, 8'd63, 8'd73);
        iCoefWe = 1'b0;
        chk("pending_midframe_write", 32'(oCoefPending), 32'd1);
        px(8'd54, 8'd64, 8'd74, 8'd54, 8'd64, 8'd74);
        px(8'd55, 8'd65, 8'd75, 8'd55, 8'd65, 8'd75);
        repeat (2) idle();
        px(8'd56, 8'd66, 8'd76, 8'd56, 8'd66, 8'd76);
        chk("pending_before_last", 32'(oCoefPending), 32'd1);
        px(8'd57, 8'd67, 8'd77, 8'd57, 8'd67, 8'd77);
        chk("pending_after_last", 32'(oCoefPending), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 2)) idle();
            px(8'(100+i), 8'(50+i), 8'(25+i), 8'd0, 8'(50+i), 8'(25+i));
        end
        repeat (4) idle();

        // Async reset with pixels in flight and a pending write
        wr(4'd2, 12'd100);
        px(8'd9, 8'd90, 8'd190, 8'd0, 8'd90, 8'd190);
        px(8'd9, 8'd91, 8'd191, 8'd0, 8'd91, 8'd191);
        px(8'd9, 8'd92, 8'd192, 8'd0, 8'd92, 8'd192);
        #1;
        reset = 1'b1;
        sb.delete();
        pos = 0;
        #1;
        chk("async_reset_g", 32'(oG), 32'd0);
        chk("async_reset_b", 32'(oB), 32'd0);
        chk("async_reset_valid", 32'(oValid), 32'd0);
        chk("async_reset_pending", 32'(oCoefPending), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 2)) idle();
            px(8'(10+i), 8'(20+i), 8'(30+i), 8'(10+i), 8'(20+i), 8'(30+i));
        end

        for (int k = 0; k < 20 && sb.size() != 0; k++) idle();
        repeat (3) idle();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
